// File: rtl/if_stage_if.sv
// Instruction-fetch bus bundle: hazard/redirect controls, instruction memory
// port and the IF/ID pipeline register outputs.
interface if_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_inst,
    output imem_addr, if_id_pc, if_id_pc_plus4, if_id_inst, if_id_valid,
           halted, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_inst,
    input  imem_addr, if_id_pc, if_id_pc_plus4, if_id_inst, if_id_valid,
           halted, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from combinational imem and
// fills the IF/ID register; handles stalls, EX redirects and end-of-program halt.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 6,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic [XLEN-1:0]   id_pc4_q, id_pc4_d;
  logic [XLEN-1:0]   id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              halted_q, halted_d;
  logic [XLEN-1:0]   fetch_cnt_q, fetch_cnt_d;

  logic              in_range;
  logic [XLEN-1:0]   target_aligned;

  assign in_range       = (pc_q[31:2] < 30'(IMEM_WORDS));
  assign target_aligned = {bus.redirect_target[31:2], 2'b00};

  // Next-state: redirect beats stall beats normal fetch in every state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    halted_d    = halted_q;
    fetch_cnt_d = fetch_cnt_q;

    if (bus.redirect_valid) begin
      pc_d       = target_aligned;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      halted_d   = 1'b0;
      state_d    = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (!bus.stall) begin
            if (in_range) begin
              id_pc_d     = pc_q;
              id_pc4_d    = pc_q + XLEN'(4);
              id_inst_d   = bus.imem_inst;
              id_valid_d  = 1'b1;
              pc_d        = pc_q + XLEN'(4);
              fetch_cnt_d = fetch_cnt_q + XLEN'(1);
            end else begin
              id_inst_d  = NOP_INST;
              id_valid_d = 1'b0;
              halted_d   = 1'b1;
              state_d    = ST_HALT;
            end
          end
        end
        ST_HALT: begin
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      id_pc_q     <= '0;
      id_pc4_q    <= '0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      halted_q    <= halted_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_pc       = id_pc_q;
  assign bus.if_id_pc_plus4 = id_pc4_q;
  assign bus.if_id_inst     = id_inst_q;
  assign bus.if_id_valid    = id_valid_q;
  assign bus.halted         = halted_q;
  assign bus.fetch_count    = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: six-word program, stalls, redirects, halt and
// asynchronous mid-run reset, with hand-computed expectations.
module tb_if_stage;

  logic clk;
  logic rst_n;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [31:0] prog [6];
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-program words read as junk.
  always_comb begin
    if (bus.imem_addr[31:2] < 30'd6)
      bus.imem_inst = prog[bus.imem_addr[4:2]];
    else
      bus.imem_inst = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] fc);
    check({tag, "_pc"},   bus.if_id_pc, pc);
    check({tag, "_pc4"},  bus.if_id_pc_plus4, pc + 32'd4);
    check({tag, "_inst"}, bus.if_id_inst, inst);
    check({tag, "_vld"},  32'(bus.if_id_valid), 32'd1);
    check({tag, "_fc"},   bus.fetch_count, fc);
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] pc);
    check({tag, "_vld"},  32'(bus.if_id_valid), 32'd0);
    check({tag, "_inst"}, bus.if_id_inst, 32'h0000_0013);
    check({tag, "_addr"}, bus.imem_addr, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prog[0] = 32'h1111_0001; prog[1] = 32'h2222_0002; prog[2] = 32'h3333_0003;
    prog[3] = 32'h4444_0004; prog[4] = 32'h5555_0005; prog[5] = 32'h6666_0006;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    rst_n = 1'b0;

    // Reset values
    step(); step();
    check("rst_addr",  bus.imem_addr, 32'h0);
    check("rst_idpc",  bus.if_id_pc, 32'h0);
    check("rst_idpc4", bus.if_id_pc_plus4, 32'h0);
    check("rst_inst",  bus.if_id_inst, 32'h13);
    check("rst_vld",   32'(bus.if_id_valid), 32'd0);
    check("rst_halt",  32'(bus.halted), 32'd0);
    check("rst_fc",    bus.fetch_count, 32'd0);

    // Free run: BOOT, six fetches, then halt
    rst_n = 1'b1;
    step();
    check("boot_vld",  32'(bus.if_id_valid), 32'd0);
    check("boot_addr", bus.imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_fetch("run", 32'(i * 4), prog[i], 32'(i + 1));
    end
    step();
    check_bubble("halt", 32'd24);
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_fc",   bus.fetch_count, 32'd6);

    // Stall has no effect in HALT
    bus.stall = 1'b1;
    step();
    check("halt_stall", 32'(bus.halted), 32'd1);
    check_bubble("halt_stall", 32'd24);
    bus.stall = 1'b0;

    // Redirect out of HALT back to 0
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    check("unhalt_flag", 32'(bus.halted), 32'd0);
    check_bubble("unhalt", 32'd0);
    step();
    check_fetch("unhalt_w0", 32'd0, prog[0], 32'd7);
    step();
    check_fetch("w1", 32'd4, prog[1], 32'd8);

    // Stall three cycles at pc=8
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", bus.imem_addr, 32'd8);
      check_fetch("stall", 32'd4, prog[1], 32'd8);
    end
    bus.stall = 1'b0;
    step();
    check_fetch("unstall", 32'd8, prog[2], 32'd9);
    check("unstall_addr", bus.imem_addr, 32'd12);

    // Redirect at pc=12 to misaligned 6 -> 4
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0000_0006;
    step();
    bus.redirect_valid = 1'b0;
    check_bubble("redir", 32'd4);
    check("redir_idpc", bus.if_id_pc, 32'd8);
    check("redir_fc",   bus.fetch_count, 32'd9);
    step();
    check_fetch("redir_w1", 32'd4, prog[1], 32'd10);
    step(); step();
    check_fetch("w3", 32'd12, prog[3], 32'd12);
    check("w3_addr", bus.imem_addr, 32'd16);

    // Stall + redirect together at pc=16: redirect wins
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0;
    step();
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    check_bubble("both", 32'd0);
    check("both_fc", bus.fetch_count, 32'd12);
    step();
    check_fetch("both_w0", 32'd0, prog[0], 32'd13);
    step(); step();
    check("pre_rst_addr", bus.imem_addr, 32'd12);
    check("pre_rst_fc",   bus.fetch_count, 32'd15);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", bus.imem_addr, 32'h0);
    check("arst_vld",  32'(bus.if_id_valid), 32'd0);
    check("arst_fc",   bus.fetch_count, 32'd0);
    check("arst_inst", bus.if_id_inst, 32'h13);
    step();
    rst_n = 1'b1;
    step();
    check("arst_boot_vld", 32'(bus.if_id_valid), 32'd0);
    step();
    check_fetch("arst_w0", 32'd0, prog[0], 32'd1);

    // Redirect to top of address space: halts with pc held
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    check_bubble("top", 32'hFFFF_FFFC);
    step();
    check("top_halt", 32'(bus.halted), 32'd1);
    check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check("top_fc",   bus.fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Owns the program counter and drives the byte address into the combinational instruction memory; imem_inst returns in the same cycle.
- Registers the fetched word into the IF/ID pipeline register for decode.
- Handles hazard-unit stalls, EX-stage redirects (branch/jump) and end-of-program halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 6, number of valid 32-bit words in instruction memory; fetch at word index >= IMEM_WORDS is out of program.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard-unit stall; holds PC and IF/ID.
- redirect_valid  in  1  EX-stage taken branch/jump.
- redirect_target  in  32  new PC; bits [1:0] are forced to 0.
- imem_addr  out  32  byte address to instruction memory; equals pc.
- imem_inst  in  32  instruction word from memory (combinational).
- if_id_pc  out  32  PC of the registered instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4.
- if_id_inst  out  32  registered instruction, or NOP_INST when invalid.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  high while in HALT.
- fetch_count  out  32  number of valid instructions captured into IF/ID.

Behaviour:
- Reset (async assert, while rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - if_id_pc=0, if_id_pc_plus4=0, if_id_inst=NOP_INST, if_id_valid=0.
  - halted=0, fetch_count=0.
- Reset assertion mid-operation discards all state immediately. Deassertion is assumed synchronous to clk by the system.
- imem_addr = pc, purely combinational.
- In-range condition: pc[31:2] < IMEM_WORDS, unsigned 30-bit compare.
- Priority each edge: redirect_valid > stall > normal.
- State BOOT:
  - Lasts exactly one cycle after reset release.
  - IF/ID keeps its reset contents; pc holds.
  - Next state is RUN.
  - A redirect in BOOT applies the redirect rule below and goes to RUN.
- State RUN, redirect_valid=1 (stall ignored):
  - pc <= {redirect_target[31:2],2'b00}.
  - IF/ID <= bubble (inst=NOP_INST, valid=0, pc fields hold their previous values).
  - State stays RUN.
- State RUN, stall=1, no redirect:
  - pc, IF/ID and fetch_count all hold.
  - No memory-range check is taken.
- State RUN, normal, pc in range:
  - if_id_pc <= pc, if_id_pc_plus4 <= pc+4 (mod 2^32), if_id_inst <= imem_inst, if_id_valid <= 1.
  - pc <= pc+4; fetch_count <= fetch_count+1 (wraps at 2^32).
- State RUN, normal, pc out of range:
  - IF/ID <= bubble; pc holds.
  - State <= HALT; halted <= 1.
- State HALT:
  - IF/ID emits bubbles; pc holds; stall has no effect.
  - redirect_valid=1 loads the target, produces a bubble, sets halted <= 0 and goes to RUN (allows loops back into the program).
- PC wrap: pc+4 from 32'hFFFF_FFFC wraps to 0. The out-of-range rule catches this first for any realistic IMEM_WORDS.
- Latency: instruction at pc is visible on if_id_* one edge after pc is presented.
- Redirect penalty: exactly one bubble in IF/ID. The ID-stage kill is handled by the hazard unit, not here.
- Simultaneous stall and redirect: redirect wins; the stall is dropped for that cycle.

Test Plan:
- Reset then free-run with program words W0..W5:
  - Edge 1 is BOOT, if_id_valid=0.
  - Edges 2..7 give if_id_pc=0,4,...,20 with inst=W0..W5, valid=1.
  - Edge 8: halted=1, valid=0, inst=32'h13, pc=24, fetch_count=6.
- Stall for 3 cycles while pc=8:
  - pc stays 8; if_id_pc stays 4 with inst W1; fetch_count frozen.
  - On release, the next edge captures pc=8 / W2.
- redirect_valid with target=32'h0000_0006 at pc=12:
  - Next edge: pc=4, if_id_valid=0, if_id_inst=32'h13.
  - Following edge: if_id_pc=4, inst=W1.
- Stall and redirect together (target=0) at pc=16: redirect wins; pc=0 and a bubble on the next edge.
- In HALT (pc=24), apply redirect target=0:
  - halted drops, one bubble.
  - Then W0 at if_id_pc=0; fetch_count continues from 6 to 7.
- Assert rst_n=0 mid-run at pc=12, between clock edges:
  - All outputs reset immediately, without waiting for clk: pc=0, valid=0, fetch_count=0.
  - After release: the BOOT bubble, then W0.
